// File: rtl/seg_mux_display.sv
// seg_mux_display: time-multiplexed seven-segment driver for a common-anode
// display (active-low segments, decimal point and anodes). The shown value is
// taken from shadow registers captured by `load`; brightness is PWM within
// each digit slot, and one blank cycle at every digit change suppresses
// ghosting.
//
// Optional feature: define SEG_LZ_SUPPRESS_EN to blank leading zeros
// (digit 0 is never blanked). Without the macro every nibble is shown.
//
// Handshake: `load` is a plain one-cycle strobe with no ready; whatever is on
// value/dp at a clock edge with load=1 is captured, and reset wins over load.
module seg_mux_display #(
    parameter int DIGITS = 8,
    parameter int DIV    = 100000,
    parameter int DUTY_W = 4
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    input  logic [DUTY_W-1:0]     brightness,
    output logic [6:0]            SEG,
    output logic                  DP,
    output logic [DIGITS-1:0]     AN
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(DIV);

    logic [4*DIGITS-1:0] sh_val;
    logic [DIGITS-1:0]   sh_dp;
    logic [CNT_W-1:0]    div_cnt;
    logic [IDX_W-1:0]    idx;
    logic [DUTY_W-1:0]   pwm;
    logic                blank;

    logic                tick;
    logic                lit;
    logic [3:0]          nibble;
    logic [6:0]          seg_next;
    logic [DIGITS-1:0]   an_next;

    // Standard active-low hex encoding, bit 6 = segment g, bit 0 = segment a.
    function automatic logic [6:0] hex7seg(input logic [3:0] n);
        case (n)
            4'h0: hex7seg = 7'b1000000;
            4'h1: hex7seg = 7'b1111001;
            4'h2: hex7seg = 7'b0100100;
            4'h3: hex7seg = 7'b0110000;
            4'h4: hex7seg = 7'b0011001;
            4'h5: hex7seg = 7'b0010010;
            4'h6: hex7seg = 7'b0000010;
            4'h7: hex7seg = 7'b1111000;
            4'h8: hex7seg = 7'b0000000;
            4'h9: hex7seg = 7'b0010000;
            4'hA: hex7seg = 7'b0001000;
            4'hB: hex7seg = 7'b0000011;
            4'hC: hex7seg = 7'b1000110;
            4'hD: hex7seg = 7'b0100001;
            4'hE: hex7seg = 7'b0000110;
            default: hex7seg = 7'b0001110;
        endcase
    endfunction

    assign tick   = (div_cnt == CNT_W'(DIV - 1));
    assign lit    = (brightness == '1) || (pwm < brightness);
    assign nibble = sh_val[4*idx +: 4];

    // Shadow registers: the scan only ever reads these, never value/dp.
    always_ff @(posedge CLK) begin
        if (reset) begin
            sh_val <= '0;
            sh_dp  <= '0;
        end else if (load) begin
            sh_val <= value;
            sh_dp  <= dp;
        end
    end

    // Slot divider, digit index with explicit wrap, and the blank flag.
    always_ff @(posedge CLK) begin
        if (reset) begin
            div_cnt <= '0;
            idx     <= '0;
            blank   <= 1'b1;
        end else begin
            blank <= tick;
            if (tick) begin
                div_cnt <= '0;
                idx     <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // PWM counter: restarts on tick and holds through the blank cycle, so the
    // first visible cycle of a slot sees pwm=0 and a digit is lit for exactly
    // `brightness` cycles; saturates at all-ones.
    always_ff @(posedge CLK) begin
        if (reset) begin
            pwm <= '0;
        end else if (tick) begin
            pwm <= '0;
        end else if (!blank && (pwm != '1)) begin
            pwm <= pwm + 1'b1;
        end
    end

`ifdef SEG_LZ_SUPPRESS_EN
    logic [DIGITS-1:0] upper_nz;

    // upper_nz[i] is set when any nibble from i up to the top is non-zero.
    always_comb begin
        logic acc;
        acc      = 1'b0;
        upper_nz = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            acc         = acc | (|sh_val[4*i +: 4]);
            upper_nz[i] = acc;
        end
    end

    // Segment pattern with leading-zero blanking; digit 0 always shows.
    always_comb begin
        seg_next = hex7seg(nibble);
        if ((idx != '0) && !upper_nz[idx])
            seg_next = 7'b1111111;
    end
`else
    // Segment pattern for the current digit.
    always_comb begin
        seg_next = hex7seg(nibble);
    end
`endif

    // Anode pattern: only the current digit, only when lit and not blanking.
    always_comb begin
        an_next = '1;
        if (lit && !blank)
            an_next[idx] = 1'b0;
    end

    // Registered pin outputs; SEG/DP keep following idx even when dark.
    always_ff @(posedge CLK) begin
        if (reset) begin
            SEG <= 7'b1111111;
            DP  <= 1'b1;
            AN  <= '1;
        end else begin
            SEG <= seg_next;
            DP  <= ~sh_dp[idx];
            AN  <= an_next;
        end
    end

endmodule

// File: tb/tb_seg_mux_display.sv
// Directed bench for seg_mux_display with DIGITS=4, DIV=8, DUTY_W=2.
// Cycle k counts clock edges since the last reset edge (k=0); slots start at
// k=1,9,17,..., the first cycle of each slot is the blank cycle.
module tb_seg_mux_display;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic [1:0]  brightness;
    logic [6:0]  SEG;
    logic        DP;
    logic [3:0]  AN;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          k        = 0;
    int          lit_cnt  = 0;
    logic [15:0] cur_val  = '0;
    logic [3:0]  cur_dp   = '0;

    // Hand-written active-low encoding, g..a.
    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg_mux_display #(.DIGITS(4), .DIV(8), .DUTY_W(2)) dut (
        .CLK        (clk),
        .reset      (reset),
        .value      (value),
        .dp         (dp),
        .load       (load),
        .brightness (brightness),
        .SEG        (SEG),
        .DP         (DP),
        .AN         (AN)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, k);
    endtask

    function automatic int digit_of(input int kk);
        return ((kk - 1) / 8) % 4;
    endfunction

    function automatic logic [3:0] exp_an(input int kk, input logic [1:0] b);
        int p;
        int pw;
        p = (kk - 1) % 8;
        if (p == 0) return 4'hf;
        pw = (p - 1 > 3) ? 3 : p - 1;
        if (b == 2'd3 || pw < int'(b)) return ~(4'b0001 << digit_of(kk));
        return 4'hf;
    endfunction

    function automatic logic [6:0] exp_seg(input int kk, input logic [15:0] v);
        int d;
        d = digit_of(kk);
`ifdef SEG_LZ_SUPPRESS_EN
        if (d > 0 && (v >> (4 * d)) == 16'h0) return 7'b1111111;
`endif
        return hex_tab[(v >> (4 * d)) & 16'hf];
    endfunction

    // One clock, then compare all outputs against the expected pattern.
    task automatic step_check();
        @(posedge clk);
        #1;
        k++;
        check("an", {12'h0, AN}, {12'h0, exp_an(k, brightness)});
        check("seg", {9'h0, SEG}, {9'h0, exp_seg(k, cur_val)});
        check("dp", {15'h0, DP}, {15'h0, ~cur_dp[digit_of(k)]});
        if (AN != 4'hf) lit_cnt++;
    endtask

    task automatic run(input int n);
        repeat (n) step_check();
    endtask

    // Load strobe for one edge; new shadow contents show from the next edge.
    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp    = d;
        load  = 1'b1;
        step_check();
        load    = 1'b0;
        cur_val = v;
        cur_dp  = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_seg", {9'h0, SEG}, 16'h007f);
            check("rst_dp", {15'h0, DP}, 16'h0001);
            check("rst_an", {12'h0, AN}, 16'h000f);
        end
        reset   = 1'b0;
        k       = 0;
        cur_val = '0;
        cur_dp  = '0;
    endtask

    initial begin
        reset      = 1'b1;
        value      = '0;
        dp         = '0;
        load       = 1'b0;
        brightness = 2'd3;
        do_reset();

        // Scan of 0x12AF at full brightness: 7 lit cycles per digit
        lit_cnt = 0;
        do_load(16'h12AF, 4'b0000);
        run(31);
        check("scan_lit", 16'(lit_cnt), 16'd28);

        // brightness=1: one lit cycle per slot
        brightness = 2'd1;
        lit_cnt = 0;
        run(32);
        check("pwm1_lit", 16'(lit_cnt), 16'd4);

        // brightness=0: dark for a whole frame
        brightness = 2'd0;
        lit_cnt = 0;
        run(32);
        check("pwm0_lit", 16'(lit_cnt), 16'd0);

        // Load on the tick edge into digit 0 (k=128)
        brightness = 2'd3;
        run(31);
        do_load(16'h0005, 4'b0000);
        step_check();
        check("lt_blank_seg", {9'h0, SEG}, 16'h0012);
        step_check();
        check("lt_seg", {9'h0, SEG}, 16'h0012);
        check("lt_an", {12'h0, AN}, 16'h000e);
        run(30);

        // Decimal point on digit 3 over three frames
        do_load(16'h0005, 4'b1000);
        run(95);

        // Leading-zero pattern
        do_load(16'h0030, 4'b0000);
        run(31);

        // Reset mid-slot, scan restarts at digit 0 with cleared shadow
        run(5);
        do_reset();
        step_check();
        step_check();
        check("rst_idx0_an", {12'h0, AN}, 16'h000e);
        check("rst_idx0_seg", {9'h0, SEG}, 16'h0040);
        run(14);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
